fetch_seq_ctrl: RTL
===================

Name: fetch_seq_ctrl

Overview:
- Sequences the fetch-stage PC against the SRAM-like instruction bus (req/addr_ok/data_ok) with at most one request outstanding.
- Arbitrates the three PC redirect sources by priority: exception flush, then eret, then taken branch.
- Buffers the returned instruction until decode accepts it.
- Sits between the PC register and the decode stage, replacing the bare PCSrc/Stall steering.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- EXC_PC, 32'hBFC00380, exception entry vector.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inst_req  out  1  request valid to the instruction bus
- inst_addr  out  32  request address (current PC)
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- fs_valid  out  1  fetch output holds a valid instruction
- fs_pc  out  32  PC of the buffered instruction
- fs_inst  out  32  buffered instruction
- de_allowin  in  1  decode accepts fs_* this cycle
- br_taken  in  1  branch redirect request
- br_target  in  32  branch target
- eret_flush  in  1  eret redirect request
- epc  in  32  eret target
- exc_flush  in  1  exception redirect request (target EXC_PC)
- fetch_busy  out  1  high whenever fs_valid=0 (stall indication for the hazard unit)

Behaviour:
- Reset (reset=1 at a rising edge):
  - state=REQ, pc=RESET_PC, cancel=0, pend_v=0.
  - fs_valid=0, fs_pc=0, fs_inst=0.
  - inst_req=0 while reset is high.
  - The first request is issued in the cycle after reset deasserts.
  - Reset asserted mid-transaction abandons the transaction. Bus-side data_ok for it is the bus's responsibility.
- Redirect selection (combinational):
  - redir = exc_flush | eret_flush | br_taken.
  - Target priority: EXC_PC if exc_flush, else epc if eret_flush, else br_target.
- States: REQ, WAIT, HOLD.
- REQ:
  - inst_req=1, inst_addr=pc.
  - redir with no addr_ok: pc <= target, stay in REQ. The address may change because the request was not accepted.
  - addr_ok with no redir: go to WAIT.
  - addr_ok with redir in the same cycle: go to WAIT, cancel <= 1, pend_v <= 1, pend_pc <= target.
- WAIT:
  - inst_req=0.
  - redir (data_ok=0): cancel <= 1, pend_pc <= target.
    - A later redirect overwrites any earlier one, including one of higher priority.
    - Only same-cycle events are priority-resolved.
  - data_ok with neither cancel nor redir this cycle: fs_inst <= inst_rdata, fs_pc <= pc, fs_valid <= 1, go to HOLD.
  - data_ok with cancel or same-cycle redir: discard data.
    - pc <= this cycle's redirect target if one is present, else pend_pc.
    - cancel <= 0, pend_v <= 0, go to REQ.
- HOLD:
  - fs_valid=1.
  - de_allowin with no redir: fs_valid <= 0, pc <= pc+4, go to REQ.
  - redir (with or without de_allowin): fs_valid <= 0, pc <= target, go to REQ. The buffered instruction is dropped.
  - Otherwise hold all outputs.
- Latency: minimum 3 cycles from REQ entry to fs_valid (addr_ok and data_ok each in the earliest possible cycle), plus 1 cycle handoff.
- pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
- fetch_busy = ~fs_valid.

Decomposition:
- Shared defines.vh:
  - RESET_PC and EXC_PC values.
  - State encodings FS_REQ=2'd0, FS_WAIT=2'd1, FS_HOLD=2'd2.
  - Existing RESETABLE and PCSIZE macros.
- One natural sub-module: fetch_redirect_sel, the combinational priority mux producing redir and target.

Test Plan:
- Reset then bus with addr_ok and data_ok 1 cycle after each request, de_allowin=1 -> fs_pc sequence BFC00000, BFC00004, BFC00008, one instruction every 4 cycles.
- br_taken=1, br_target=80001000 in REQ before addr_ok -> inst_addr becomes 80001000 the next cycle; no request to the old PC is accepted.
- br_taken in WAIT, data_ok 3 cycles later -> old data discarded, fs_valid stays 0, next inst_addr=br_target.
- exc_flush, eret_flush (epc=80000010) and br_taken all high in one cycle in HOLD -> fs_valid drops, next inst_addr=BFC00380.
- de_allowin=0 for 5 cycles in HOLD -> fs_pc and fs_inst stable, inst_req=0, then a single advance to pc+4.
- pc=FFFFFFFC handed off -> next inst_addr=00000000.
- Reset asserted in WAIT -> next cycle state REQ, fs_valid=0, inst_req=0; first request after deassert has inst_addr=BFC00000.

Source files
------------

// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: reset/exception vectors,
// state encoding, debug view and the sequential-PC helper.
package fetch_seq_ctrl_pkg;

    localparam int PCSIZE = 32;

    // Register bits in this block are reset synchronously.
    localparam bit RESETABLE = 1'b1;

    localparam logic [PCSIZE-1:0] RESET_PC_DEF = 32'hBFC00000;
    localparam logic [PCSIZE-1:0] EXC_PC_DEF   = 32'hBFC00380;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fs_state_e;

    // Debug view of the sequencer's control state.
    typedef struct packed {
        fs_state_e state;
        logic      cancel;
        logic      pend_v;
    } fs_dbg_t;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [PCSIZE-1:0] pc_next(input logic [PCSIZE-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// Priority mux over the three PC redirect sources:
// exception flush, then eret, then taken branch.
module fetch_redirect_sel
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [PCSIZE-1:0] EXC_PC = EXC_PC_DEF
) (
    input  logic              exc_flush,
    input  logic              eret_flush,
    input  logic [PCSIZE-1:0] epc,
    input  logic              br_taken,
    input  logic [PCSIZE-1:0] br_target,
    output logic              redir,
    output logic [PCSIZE-1:0] target
);

    // Any source redirects; the highest-priority source supplies the target.
    always_comb begin
        redir  = exc_flush | eret_flush | br_taken;
        target = br_target;
        if (exc_flush) begin
            target = EXC_PC;
        end else if (eret_flush) begin
            target = epc;
        end
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencer: drives the PC onto the SRAM-like instruction bus
// with at most one request outstanding, applies redirects, and buffers the
// returned instruction until decode takes it.
//
// Handshakes:
//   bus request : inst_req is the valid, inst_addr_ok the ready; the request
//                 transfers in a cycle where both are high. inst_addr may
//                 change while inst_req is high and inst_addr_ok is low.
//   bus response: inst_data_ok is a one-cycle valid with no back-pressure.
//   decode      : fs_valid is the valid, de_allowin the ready; fs_* transfer
//                 in a cycle where both are high.
// A request accepted before a redirect is still outstanding; its data is
// dropped on arrival (cancel) and the redirect target is fetched next.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [PCSIZE-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [PCSIZE-1:0] EXC_PC   = EXC_PC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    output logic              inst_req,
    output logic [PCSIZE-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic              fs_valid,
    output logic [PCSIZE-1:0] fs_pc,
    output logic [31:0]       fs_inst,
    input  logic              de_allowin,
    input  logic              br_taken,
    input  logic [PCSIZE-1:0] br_target,
    input  logic              eret_flush,
    input  logic [PCSIZE-1:0] epc,
    input  logic              exc_flush,
    output logic              fetch_busy,
    output fs_dbg_t           dbg
);

    fs_state_e         state;
    logic [PCSIZE-1:0] pc;
    logic              cancel;
    logic              pend_v;
    logic [PCSIZE-1:0] pend_pc;

    logic              redir;
    logic [PCSIZE-1:0] target;

    fetch_redirect_sel #(
        .EXC_PC (EXC_PC)
    ) u_redirect_sel (
        .exc_flush  (exc_flush),
        .eret_flush (eret_flush),
        .epc        (epc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .redir      (redir),
        .target     (target)
    );

    // Request is presented only in REQ and never while reset is held.
    assign inst_req   = (state == FS_REQ) && !reset;
    assign inst_addr  = pc;
    assign fetch_busy = ~fs_valid;

    assign dbg = '{state: state, cancel: cancel, pend_v: pend_v};

    // Fetch sequencer: request, wait for data (or discard it), hold for decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FS_REQ;
            pc       <= RESET_PC;
            cancel   <= 1'b0;
            pend_v   <= 1'b0;
            pend_pc  <= RESET_PC;
            fs_valid <= 1'b0;
            fs_pc    <= '0;
            fs_inst  <= '0;
        end else begin
            case (state)
                FS_REQ: begin
                    if (inst_addr_ok) begin
                        // Request to pc is on the bus; a same-cycle redirect
                        // can only be honoured after its data returns.
                        state <= FS_WAIT;
                        if (redir) begin
                            cancel  <= 1'b1;
                            pend_v  <= 1'b1;
                            pend_pc <= target;
                        end
                    end else if (redir) begin
                        // Not yet accepted, so the address can simply move.
                        pc <= target;
                    end
                end

                FS_WAIT: begin
                    if (inst_data_ok) begin
                        if (cancel || redir) begin
                            pc     <= redir ? target : pend_pc;
                            cancel <= 1'b0;
                            pend_v <= 1'b0;
                            state  <= FS_REQ;
                        end else begin
                            fs_inst  <= inst_rdata;
                            fs_pc    <= pc;
                            fs_valid <= 1'b1;
                            state    <= FS_HOLD;
                        end
                    end else if (redir) begin
                        // Latest redirect wins over any earlier pending one.
                        cancel  <= 1'b1;
                        pend_v  <= 1'b1;
                        pend_pc <= target;
                    end
                end

                FS_HOLD: begin
                    if (redir) begin
                        fs_valid <= 1'b0;
                        pc       <= target;
                        state    <= FS_REQ;
                    end else if (de_allowin) begin
                        fs_valid <= 1'b0;
                        pc       <= pc_next(pc);
                        state    <= FS_REQ;
                    end
                end

                default: begin
                    state <= FS_REQ;
                end
            endcase
        end
    end

endmodule
